// File: rtl/mem_dm_access_ctrl.sv
// MEM-stage data-memory access controller: turns a load/store into a
// valid/ready bus request, captures the response and stalls the pipe meanwhile.
module mem_dm_access_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_flush,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dm_req_valid,
    input  logic        dm_req_ready,
    output logic        dm_req_wr,
    output logic [31:0] dm_req_addr,
    output logic [3:0]  dm_req_wstrb,
    output logic [31:0] dm_req_wdata,
    input  logic        dm_resp_valid,
    input  logic [31:0] dm_resp_rdata,
    output logic [31:0] mem_dm_out,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        mem_addr_err,
    output logic        mem_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
    localparam logic       WD_EN = (MAX_WAIT != 0);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  cnt_inc;
    logic        wd_hit;
    logic        misalign;
    logic        addr_err;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic        lat_req;
    logic        cnt_clr;
    logic        cnt_run;
    logic        cap_resp;
    logic        fire_to;

    always_comb begin
        misalign = 1'b0;
        wstrb_c  = 4'b1111;
        wdata_c  = req_wdata;
        unique case (req_size)
            2'd0: begin
                wstrb_c = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                misalign = req_addr[0];
                wstrb_c  = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {2{req_wdata[15:0]}};
            end
            2'd2: misalign = (req_addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    assign addr_err     = req_valid & misalign;
    assign mem_addr_err = addr_err;

    // Watchdog fires once the current cycle completes MAX_WAIT cycles of waiting.
    assign cnt_inc = wait_cnt + 8'd1;
    assign wd_hit  = WD_EN && (cnt_inc == MAX_W);

    assign dm_req_valid = (state == S_REQ);
    assign mem_done     = (state == S_DONE);
    assign mem_stall    = (req_valid & ~addr_err & (state != S_DONE))
                        | (state == S_DRAIN);

    always_comb begin
        state_nxt = state;
        lat_req   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_run   = 1'b0;
        cap_resp  = 1'b0;
        fire_to   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_valid && !addr_err && !mem_flush) begin
                    lat_req   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (dm_req_ready) begin
                    cnt_clr   = 1'b1;
                    state_nxt = mem_flush ? S_DRAIN : S_WAIT;
                end else if (mem_flush) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_run = 1'b1;
                if (dm_resp_valid) begin
                    cap_resp  = 1'b1;
                    state_nxt = S_DONE;
                end else if (mem_flush) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_DRAIN;
                end else if (wd_hit) begin
                    fire_to   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DRAIN: begin
                cnt_run = 1'b1;
                if (dm_resp_valid || wd_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            wait_cnt     <= 8'd0;
            dm_req_wr    <= 1'b0;
            dm_req_addr  <= 32'd0;
            dm_req_wstrb <= 4'd0;
            dm_req_wdata <= 32'd0;
            mem_dm_out   <= 32'd0;
            mem_timeout  <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_timeout <= fire_to;
            if (lat_req) begin
                dm_req_wr    <= req_wr;
                dm_req_addr  <= {req_addr[31:2], 2'b00};
                dm_req_wstrb <= req_wr ? wstrb_c : 4'b0000;
                dm_req_wdata <= wdata_c;
            end
            if (cnt_clr) begin
                wait_cnt <= 8'd0;
            end else if (cnt_run) begin
                wait_cnt <= cnt_inc;
            end
            if (cap_resp) begin
                mem_dm_out <= dm_req_wr ? 32'd0 : dm_resp_rdata;
            end else if (fire_to) begin
                mem_dm_out <= 32'd0;
            end
        end
    end

endmodule
